eth_hdr_classify: RTL and testbench

Parametrised Ethernet header classifier for the router output-port-lookup pipeline. On the first data word of each packet, it does four things: extracts the ethertype (skipping one 802.1Q tag), checks the destination MAC against the per-port MAC of the ingress port, flags broad-/multicast and CPU-originated traffic, and detects malformed source-port encodings. Results are queued in an internal first-word-fall-through FIFO of configurable depth, which the lookup state machine consumes one entry per packet.

---
 rtl/eth_hdr_classify.sv | 183 ++++++++++++++++++
 tb/tb_eth_hdr_classify.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/eth_hdr_classify.sv
// Ethernet header classifier: decodes the first word of each packet into
// flags and queues one result per packet in a small first-word-fall-through FIFO.
module eth_hdr_classify #(
    parameter int C_S_AXIS_TDATA_WIDTH = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int MAC_WIDTH            = 48,
    parameter int NUM_PORTS            = 4,
    parameter int SRC_PORT_POS         = 16,
    parameter int FIFO_DEPTH_BITS      = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   i_tdata,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   i_tuser,
    input  logic                              i_pkt_word1,
    input  logic [NUM_PORTS*MAC_WIDTH-1:0]    i_macs,
    input  logic                              i_rd_from_magic,
    output logic                              o_eth_out_valid,
    output logic                              o_is_for_us,
    output logic                              o_is_bmcast,
    output logic                              o_is_arp,
    output logic                              o_is_ipv4,
    output logic                              o_is_ipv6,
    output logic                              o_is_vlan,
    output logic                              o_from_cpu,
    output logic                              o_port_err,
    output logic [11:0]                       o_vlan_id,
    output logic                              o_fifo_full,
    output logic [15:0]                       o_overflow_cnt
);

    localparam int SPW   = 2 * NUM_PORTS;
    localparam int PW    = FIFO_DEPTH_BITS;
    localparam int CW    = FIFO_DEPTH_BITS + 1;
    localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
    localparam logic [CW-1:0] DEPTH_C = {1'b1, {PW{1'b0}}};

    typedef struct packed {
        logic        for_us;
        logic        bmcast;
        logic        arp;
        logic        ipv4;
        logic        ipv6;
        logic        vlan;
        logic        from_cpu;
        logic        port_err;
        logic [11:0] vlan_id;
    } result_t;

    logic [SPW-1:0]       sp_s;
    logic [MAC_WIDTH-1:0] dmac_s;
    logic [15:0]          eth_type_s;
    logic [15:0]          eff_type_s;
    logic                 onehot_s;
    logic                 cpu_bit_s;
    logic                 mac_hit_s;
    result_t              cls_s;

    result_t              s1_q, s1_d;
    logic                 wr_req_q, wr_req_d;
    result_t              mem_q [DEPTH];
    result_t              mem_d [DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [15:0]          ovf_q, ovf_d;
    logic                 full_s;
    logic                 rd_en_s;
    logic                 wr_en_s;
    result_t              head_s;
    logic                 unused_s;

    assign unused_s = ^{i_tdata, i_tuser};

    // Decode the header word into the result flags.
    always_comb begin
        sp_s       = i_tuser[SRC_PORT_POS +: SPW];
        dmac_s     = i_tdata[255 -: MAC_WIDTH];
        eth_type_s = i_tdata[159:144];
        cls_s      = '0;
        cpu_bit_s  = 1'b0;
        mac_hit_s  = 1'b0;
        if (eth_type_s == 16'h8100) begin
            cls_s.vlan    = 1'b1;
            cls_s.vlan_id = i_tdata[139:128];
            eff_type_s    = i_tdata[127:112];
        end else begin
            eff_type_s    = eth_type_s;
        end
        case (eff_type_s)
            16'h0800: cls_s.ipv4 = 1'b1;
            16'h0806: cls_s.arp  = 1'b1;
            16'h86DD: cls_s.ipv6 = 1'b1;
            default:  cls_s.ipv4 = 1'b0;
        endcase
        // Even bits are physical ports, odd bits the matching CPU ports.
        for (int i = 0; i < NUM_PORTS; i++) begin
            cpu_bit_s = cpu_bit_s | sp_s[2*i+1];
            mac_hit_s = mac_hit_s |
                        (sp_s[2*i] && (dmac_s == i_macs[i*MAC_WIDTH +: MAC_WIDTH]));
        end
        onehot_s       = (sp_s != '0) && ((sp_s & (sp_s - SPW'(1))) == '0);
        cls_s.port_err = !onehot_s;
        cls_s.from_cpu = onehot_s && cpu_bit_s;
        cls_s.bmcast   = i_tdata[248];
        cls_s.for_us   = onehot_s && !cpu_bit_s && (cls_s.bmcast || mac_hit_s);
    end

    // Stage 1 capture and the write request for the following edge.
    always_comb begin
        wr_req_d = i_pkt_word1;
        if (i_pkt_word1) begin
            s1_d = cls_s;
        end else begin
            s1_d = s1_q;
        end
    end

    // FIFO pointer, occupancy and overflow bookkeeping.
    always_comb begin
        full_s   = (count_q == DEPTH_C);
        rd_en_s  = i_rd_from_magic && (count_q != '0);
        wr_en_s  = wr_req_q && (!full_s || rd_en_s);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        if (wr_en_s) begin
            mem_d[wr_ptr_q] = s1_q;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end else if (wr_req_q && (ovf_q != 16'hFFFF)) begin
            ovf_d = ovf_q + 16'd1;
        end else begin
            ovf_d = ovf_q;
        end
        if (rd_en_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_en_s, rd_en_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q     <= '0;
            wr_req_q <= 1'b0;
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 16'd0;
        end else begin
            s1_q     <= s1_d;
            wr_req_q <= wr_req_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    assign head_s          = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign o_eth_out_valid = (count_q != '0);
    assign o_fifo_full     = full_s;
    assign o_overflow_cnt  = ovf_q;
    assign o_is_for_us     = head_s.for_us;
    assign o_is_bmcast     = head_s.bmcast;
    assign o_is_arp        = head_s.arp;
    assign o_is_ipv4       = head_s.ipv4;
    assign o_is_ipv6       = head_s.ipv6;
    assign o_is_vlan       = head_s.vlan;
    assign o_from_cpu      = head_s.from_cpu;
    assign o_port_err      = head_s.port_err;
    assign o_vlan_id       = head_s.vlan_id;

endmodule

// File: tb/tb_eth_hdr_classify.sv
// Randomised and directed bench for eth_hdr_classify, checked every cycle
// against a queue-based reference model of the classifier and result FIFO.
module tb_eth_hdr_classify;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [255:0]  tdata;
    logic [127:0]  tuser;
    logic          word1;
    logic [191:0]  macs;
    logic          rd;
    logic          valid, for_us, bmcast, is_arp, is_ipv4, is_ipv6, is_vlan, from_cpu, port_err;
    logic [11:0]   vlan_id;
    logic          full;
    logic [15:0]   ovf;

    int n_checks = 0;
    int n_fail   = 0;

    logic [19:0] q[$];
    logic [19:0] pend;
    logic        pend_v;
    logic [15:0] m_ovf;

    wire [19:0] head = {for_us, bmcast, is_arp, is_ipv4, is_ipv6, is_vlan, from_cpu, port_err, vlan_id};

    eth_hdr_classify dut (
        .clk(clk), .reset(rst_n), .i_tdata(tdata), .i_tuser(tuser),
        .i_pkt_word1(word1), .i_macs(macs), .i_rd_from_magic(rd),
        .o_eth_out_valid(valid), .o_is_for_us(for_us), .o_is_bmcast(bmcast),
        .o_is_arp(is_arp), .o_is_ipv4(is_ipv4), .o_is_ipv6(is_ipv6),
        .o_is_vlan(is_vlan), .o_from_cpu(from_cpu), .o_port_err(port_err),
        .o_vlan_id(vlan_id), .o_fifo_full(full), .o_overflow_cnt(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference classification from the header rules:
    // {for_us, bmcast, arp, ipv4, ipv6, vlan, from_cpu, port_err, vlan_id}
    function automatic logic [19:0] ref_cls(input logic [255:0] d, input logic [7:0] sp,
                                           input logic [191:0] m);
        logic [15:0] t;
        logic        vl, err, cpu, hit, bm, fu;
        logic [11:0] vid;
        t = d[159:144]; vl = 1'b0; vid = 12'd0; cpu = 1'b0; hit = 1'b0;
        if (t == 16'h8100) begin
            vl = 1'b1; vid = d[139:128]; t = d[127:112];
        end
        err = ($countones(sp) != 1);
        if (!err) begin
            for (int k = 0; k < 8; k++) begin
                if (sp[k]) begin
                    cpu = (k % 2) == 1;
                    hit = (d[255:208] == m[(k/2)*48 +: 48]);
                end
            end
        end
        bm = d[248];
        fu = !err && !cpu && (bm || hit);
        return {fu, bm, t == 16'h0806, t == 16'h0800, t == 16'h86DD, vl, cpu, err, vid};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete(); pend_v = 1'b0; pend = 20'd0; m_ovf = 16'd0;
        end else begin
            if (rd && q.size() > 0) q.delete(0);
            if (pend_v) begin
                if (q.size() < 4) q.push_back(pend);
                else if (m_ovf != 16'hFFFF) m_ovf = m_ovf + 16'd1;
            end
            pend_v = word1;
            if (word1) pend = ref_cls(tdata, tuser[23:16], macs);
        end
    end

    always @(negedge clk) begin
        check("valid", valid, q.size() != 0);
        check("full", full, q.size() == 4);
        check("ovf_cnt", ovf, m_ovf);
        check("head", head, (q.size() != 0) ? q[0] : 20'd0);
    end

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic drive_hdr(input logic [47:0] dm, input logic [15:0] ty, input logic [15:0] tci,
                             input logic [15:0] inner, input logic [7:0] sp);
        tdata = rand256();
        tdata[255:208] = dm;
        tdata[159:144] = ty;
        tdata[143:128] = tci;
        tdata[127:112] = inner;
        tuser = {$urandom, $urandom, $urandom, $urandom};
        tuser[23:16] = sp;
        word1 = 1'b1;
    endtask

    task automatic run_one(input string nm, input logic [47:0] dm, input logic [15:0] ty,
                           input logic [15:0] tci, input logic [15:0] inner,
                           input logic [7:0] sp, input logic [19:0] exp);
        @(negedge clk); drive_hdr(dm, ty, tci, inner, sp);
        @(negedge clk); word1 = 1'b0;
        check({nm, "_latency"}, valid, 1'b0);
        @(negedge clk);
        check({nm, "_valid"}, valid, 1'b1);
        check(nm, head, exp);
        rd = 1'b1;
        @(negedge clk); rd = 1'b0;
        check({nm, "_drained"}, valid, 1'b0);
    endtask

    function automatic logic [47:0] mac_of(input int p);
        return macs[p*48 +: 48];
    endfunction

    initial begin
        logic [47:0] dm;
        logic [15:0] ty, inner;
        logic [7:0]  sp;
        rst_n = 1'b0; word1 = 1'b0; rd = 1'b0; tdata = '0; tuser = '0;
        macs = {48'h02_11_22_33_44_03, 48'h02_11_22_33_44_02,
                48'h02_11_22_33_44_01, 48'h02_11_22_33_44_00};
        repeat (2) @(negedge clk);
        check("rst_valid", valid, 1'b0);
        check("rst_full", full, 1'b0);
        check("rst_ovf", ovf, 16'd0);
        check("rst_head", head, 20'd0);
        rst_n = 1'b1;

        run_one("ipv4_p1", mac_of(1), 16'h0800, 16'h0, 16'h0, 8'h04, 20'h90000);
        run_one("vlan_v6_bc", 48'hFFFF_FFFF_FFFF, 16'h8100, 16'h0123, 16'h86DD, 8'h01, 20'hCC123);
        run_one("arp_miss_p3", 48'h02_AA_BB_CC_DD_EE, 16'h0806, 16'h0, 16'h0, 8'h40, 20'h20000);
        run_one("from_cpu", mac_of(0), 16'h0800, 16'h0, 16'h0, 8'h02, 20'h12000);
        run_one("sp_two_hot", mac_of(0), 16'h0800, 16'h0, 16'h0, 8'h05, 20'h11000);
        run_one("sp_zero", mac_of(0), 16'h0800, 16'h0, 16'h0, 8'h00, 20'h11000);
        run_one("double_tag", mac_of(2), 16'h8100, 16'h0ABC, 16'h8100, 8'h10, 20'h84ABC);

        // Six back-to-back headers into a depth-4 FIFO with no reads.
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk); drive_hdr(mac_of(0), 16'h8100, 16'(k), 16'h0800, 8'h01);
        end
        @(negedge clk); word1 = 1'b0;
        repeat (2) @(negedge clk);
        check("ovf_full", full, 1'b1);
        check("ovf_count", ovf, 16'd2);
        for (int k = 1; k <= 4; k++) begin
            check("ovf_order", head, 20'h94000 | 20'(k));
            rd = 1'b1;
            @(negedge clk); rd = 1'b0;
        end
        check("ovf_empty", valid, 1'b0);

        // Reset with three entries queued.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); drive_hdr(mac_of(k), 16'h0800, 16'h0, 16'h0, 8'(1 << (2*k)));
        end
        @(negedge clk); word1 = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_rst_valid", valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", valid, 1'b0);
        check("mid_rst_ovf", ovf, 16'd0);
        check("mid_rst_head", head, 20'd0);
        check("mid_rst_full", full, 1'b0);
        @(negedge clk); rst_n = 1'b1;
        run_one("post_rst", mac_of(2), 16'h0806, 16'h0, 16'h0, 8'h10, 20'hA0000);

        // Random traffic: a fill-heavy phase, then a drain-heavy phase.
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            word1 = ($urandom % 2) == 0;
            rd = (n < 300) ? (($urandom % 4) == 0) : (($urandom % 3) != 0);
            if (word1) begin
                case ($urandom % 4)
                    0: dm = 48'hFFFF_FFFF_FFFF;
                    1: dm = {$urandom, 16'(($urandom))};
                    default: dm = mac_of(int'($urandom % 4));
                endcase
                case ($urandom % 5)
                    0: inner = 16'h0800;
                    1: inner = 16'h0806;
                    2: inner = 16'h86DD;
                    3: inner = 16'h8100;
                    default: inner = 16'($urandom);
                endcase
                ty = (($urandom % 3) == 0) ? 16'h8100 : inner;
                sp = (($urandom % 4) == 0) ? 8'($urandom) : 8'(1 << ($urandom % 8));
                drive_hdr(dm, ty, 16'($urandom), inner, sp);
            end
        end
        @(negedge clk); word1 = 1'b0; rd = 1'b0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
